// File: rtl/pingpong_loader5_pkg.sv
// rtl/pingpong_loader5_pkg.sv - shared constants for the ping-pong loader
package pingpong_loader5_pkg;

  // Default word width; must track the downstream 2:1 mux data width.
  localparam int DEF_WIDTH = 5;

  // Bank index values carried by the read and write pointers.
  localparam logic BANK_A = 1'b0;
  localparam logic BANK_B = 1'b1;

  // Occupancy values for the two-entry buffer.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

endpackage

// File: rtl/pingpong_loader5.sv
// rtl/pingpong_loader5.sv - two-entry ping-pong buffer feeding a 2:1 mux
module pingpong_loader5
  import pingpong_loader5_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       count,
  output logic [CNT_W-1:0] word_cnt
);

  logic [WIDTH-1:0] bank_a_q, bank_a_d;
  logic [WIDTH-1:0] bank_b_q, bank_b_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

  logic push;
  logic pop;

  // Handshake decode depends only on registered occupancy, so neither
  // ready nor valid has a combinational path from the opposite side.
  assign in_ready  = (count_q != FULL);
  assign out_valid = (count_q != EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign a_out    = bank_a_q;
  assign b_out    = bank_b_q;
  assign sel      = rd_ptr_q;
  assign count    = count_q;
  assign word_cnt = word_cnt_q;

  // Next-state: flush clears everything but the delivered count; otherwise
  // a push writes the bank under wr_ptr, which is never the bank being read
  // while a word is pending, so the mux output holds until popped.
  always_comb begin
    bank_a_d   = bank_a_q;
    bank_b_d   = bank_b_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;
    if (flush) begin
      bank_a_d = '0;
      bank_b_d = '0;
      wr_ptr_d = BANK_A;
      rd_ptr_d = BANK_A;
      count_d  = EMPTY;
    end else begin
      if (push) begin
        if (wr_ptr_q == BANK_A) begin
          bank_a_d = in_data;
        end else begin
          bank_b_d = in_data;
        end
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d   = ~rd_ptr_q;
        word_cnt_d = word_cnt_q + CNT_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous active-low reset overriding all else.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_a_q   <= '0;
      bank_b_q   <= '0;
      wr_ptr_q   <= BANK_A;
      rd_ptr_q   <= BANK_A;
      count_q    <= EMPTY;
      word_cnt_q <= '0;
    end else begin
      bank_a_q   <= bank_a_d;
      bank_b_q   <= bank_b_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
    end
  end

endmodule

// File: tb/tb_pingpong_loader5.sv
// tb/tb_pingpong_loader5.sv - directed self-checking bench for pingpong_loader5
module tb_pingpong_loader5;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [4:0] in_data;
  logic [4:0] a_out;
  logic [4:0] b_out;
  logic       sel;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] count;
  logic [7:0] word_cnt;

  int tests;
  int fails;

  pingpong_loader5 #(.WIDTH(5), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .a_out     (a_out),
    .b_out     (b_out),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .word_cnt  (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value seen by the downstream mux.
  wire [4:0] mux_out = sel ? b_out : a_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle outputs before checking.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] q[$];
    logic [4:0] d;
    int pops;
    int guard;

    tests     = 0;
    fails     = 0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 5'h00;
    out_ready = 1'b0;
    step();
    step();

    // Reset state
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_a", 32'(a_out), 32'h00);
    chk("rst_b", 32'(b_out), 32'h00);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);

    // 1: single push into empty buffer
    rst_n = 1'b1;
    step();
    in_valid = 1'b1;
    in_data  = 5'h15;
    step();
    in_valid = 1'b0;
    chk("s1_a", 32'(a_out), 32'h15);
    chk("s1_sel", 32'(sel), 32'd0);
    chk("s1_out_valid", 32'(out_valid), 32'd1);
    chk("s1_count", 32'(count), 32'd1);
    chk("s1_in_ready", 32'(in_ready), 32'd1);
    chk("s1_mux", 32'(mux_out), 32'h15);

    // clear back to a known empty state
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_count", 32'(count), 32'd0);
    chk("fl_a", 32'(a_out), 32'h00);
    chk("fl_word_cnt", 32'(word_cnt), 32'd0);

    // 2: fill both banks, third push ignored
    in_valid = 1'b1;
    in_data  = 5'h0A;
    step();
    in_data  = 5'h1F;
    step();
    chk("s2_a", 32'(a_out), 32'h0A);
    chk("s2_b", 32'(b_out), 32'h1F);
    chk("s2_count", 32'(count), 32'd2);
    chk("s2_in_ready", 32'(in_ready), 32'd0);
    in_data = 5'h03;
    step();
    in_valid = 1'b0;
    chk("s2_full_a", 32'(a_out), 32'h0A);
    chk("s2_full_b", 32'(b_out), 32'h1F);
    chk("s2_full_count", 32'(count), 32'd2);

    // 3: drain two words in order
    out_ready = 1'b1;
    chk("s3_sel0", 32'(sel), 32'd0);
    chk("s3_mux0", 32'(mux_out), 32'h0A);
    step();
    chk("s3_sel1", 32'(sel), 32'd1);
    chk("s3_mux1", 32'(mux_out), 32'h1F);
    chk("s3_count1", 32'(count), 32'd1);
    chk("s3_in_ready1", 32'(in_ready), 32'd1);
    step();
    chk("s3_count", 32'(count), 32'd0);
    chk("s3_word_cnt", 32'(word_cnt), 32'd2);
    chk("s3_out_valid", 32'(out_valid), 32'd0);
    step();
    out_ready = 1'b0;
    chk("s3_empty_word_cnt", 32'(word_cnt), 32'd2);
    chk("s3_empty_count", 32'(count), 32'd0);
    chk("s3_keep_a", 32'(a_out), 32'h0A);

    // 4: simultaneous push and pop at count 1
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b1;
    in_data  = 5'h01;
    step();
    chk("s4_pre_a", 32'(a_out), 32'h01);
    in_data   = 5'h02;
    out_ready = 1'b1;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("s4_count", 32'(count), 32'd1);
    chk("s4_sel", 32'(sel), 32'd1);
    chk("s4_b", 32'(b_out), 32'h02);
    chk("s4_a_kept", 32'(a_out), 32'h01);
    chk("s4_word_cnt", 32'(word_cnt), 32'd3);
    chk("s4_mux", 32'(mux_out), 32'h02);

    // 5: flush while full with both handshakes active, then reset mid-stream
    in_valid = 1'b1;
    in_data  = 5'h04;
    step();
    chk("s5_full", 32'(count), 32'd2);
    chk("s5_a", 32'(a_out), 32'h04);
    in_data   = 5'h09;
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("s5_fl_count", 32'(count), 32'd0);
    chk("s5_fl_sel", 32'(sel), 32'd0);
    chk("s5_fl_a", 32'(a_out), 32'h00);
    chk("s5_fl_b", 32'(b_out), 32'h00);
    chk("s5_fl_word_cnt", 32'(word_cnt), 32'd3);
    in_valid  = 1'b1;
    in_data   = 5'h07;
    step();
    out_ready = 1'b1;
    step();
    chk("s5_word_cnt4", 32'(word_cnt), 32'd4);
    rst_n = 1'b0;
    step();
    chk("s5_rst_word_cnt", 32'(word_cnt), 32'd0);
    chk("s5_rst_count", 32'(count), 32'd0);
    chk("s5_rst_a", 32'(a_out), 32'h00);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b1;
    step();

    // 6: stream 256 words at full throughput
    pops      = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 256; i++) begin
      d = 5'(i * 7 + 3);
      in_data = d;
      chk("s6_in_ready", 32'(in_ready), 32'd1);
      q.push_back(d);
      if (out_valid) begin
        chk("s6_order", 32'(mux_out), 32'(q[0]));
        void'(q.pop_front());
        pops++;
      end
      step();
    end
    in_valid = 1'b0;
    guard    = 0;
    while (out_valid && guard < 4) begin
      chk("s6_order_tail", 32'(mux_out), 32'(q[0]));
      void'(q.pop_front());
      pops++;
      guard++;
      step();
    end
    out_ready = 1'b0;
    chk("s6_drained", 32'(out_valid), 32'd0);
    chk("s6_pops", 32'(pops), 32'd256);
    chk("s6_queue_empty", 32'(q.size()), 32'd0);
    chk("s6_word_cnt_wrap", 32'(word_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
